// File: rtl/edge_event_arbiter.sv
// rtl/edge_event_arbiter.sv - round-robin rising-edge event scheduler (optional EDGE_SYNC_EN input synchronizer)
module edge_event_arbiter #(
    parameter int  N   = 4,
    localparam int IDW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   in,
    input  logic           evt_ready,
    input  logic           ovf_clr,
    output logic           evt_valid,
    output logic [IDW-1:0] evt_id,
    output logic [N-1:0]   pend,
    output logic [N-1:0]   ovf
);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   edge_src;
    logic [N-1:0]   in_q, in_qq;
    logic [N-1:0]   rise;
    logic [N-1:0]   pend_q, pend_d;
    logic [N-1:0]   ovf_q, ovf_d;
    logic [N-1:0]   acc_vec;
    logic [N-1:0]   cand;
    logic [N-1:0]   one_hot_base;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [IDW-1:0] id_inc;
    logic           acc;

`ifdef EDGE_SYNC_EN
    logic [N-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= in;
            sync2_q <= sync1_q;
        end
    end

    assign edge_src = sync2_q;
`else
    assign edge_src = in;
`endif

    // First index at or after start (wrapping modulo N) whose bit is set in v.
    function automatic logic [IDW-1:0] pick(input logic [N-1:0] v, input logic [IDW-1:0] start);
        logic [IDW-1:0] res;
        logic [IDW-1:0] sel;
        logic           found;
        int             idx;
        res   = start;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = int'(start) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            sel = IDW'(idx);
            if (!found && v[sel]) begin
                res   = sel;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    assign one_hot_base = {{(N-1){1'b0}}, 1'b1};
    assign evt_valid    = (state_q == OFFER);
    assign acc          = evt_valid & evt_ready;
    assign acc_vec      = acc ? (one_hot_base << id_q) : '0;
    assign rise         = in_q & ~in_qq;
    assign id_inc       = (id_q == IDW'(N - 1)) ? '0 : id_q + IDW'(1);

    // A rise on the channel being accepted is a fresh event, not an overflow.
    assign pend_d = rise | (pend_q & ~acc_vec);
    assign ovf_d  = (ovf_q & ~{N{ovf_clr}}) | (rise & pend_q & ~acc_vec);
    assign cand   = pend_d;

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (|pend_q) begin
                    state_d = OFFER;
                    id_d    = pick(pend_q, ptr_q);
                end
            end
            OFFER: begin
                if (acc) begin
                    ptr_d = id_inc;
                    if (|cand) begin
                        id_d = pick(cand, id_inc);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q    <= '0;
            in_qq   <= '0;
            pend_q  <= '0;
            ovf_q   <= '0;
            ptr_q   <= '0;
            id_q    <= '0;
            state_q <= IDLE;
        end else begin
            in_q    <= edge_src;
            in_qq   <= in_q;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            state_q <= state_d;
        end
    end

    assign evt_id = id_q;
    assign pend   = pend_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb/tb_edge_event_arbiter.sv - self-checking bench for edge_event_arbiter
module tb_edge_event_arbiter;

    localparam int N = 4;
`ifdef EDGE_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] in_s;
    logic         rdy;
    logic         clr;
    logic         evt_valid;
    logic [1:0]   evt_id;
    logic [N-1:0] pend;
    logic [N-1:0] ovf;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    edge_event_arbiter #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in_s),
        .evt_ready (rdy),
        .ovf_clr   (clr),
        .evt_valid (evt_valid),
        .evt_id    (evt_id),
        .pend      (pend),
        .ovf       (ovf)
    );

    // Reference model: h[k] is the input sampled k+1 edges ago.
    logic [N-1:0] h [0:3];
    logic [N-1:0] m_pend;
    logic [N-1:0] m_ovf;
    bit           m_valid;
    int           m_id;
    int           m_ptr;

    function automatic int rr_search(input logic [N-1:0] v, input int start);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (start + k) % N;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) h[k] = '0;
        m_pend  = '0;
        m_ovf   = '0;
        m_valid = 0;
        m_id    = 0;
        m_ptr   = 0;
    endtask

    task automatic model_edge(input logic [N-1:0] s_in, input logic s_rdy, input logic s_clr);
        logic [N-1:0] rise;
        logic [N-1:0] np;
        bit           acc;
        bit           kept;
        int           acc_ch;
        int           j;
        rise   = h[SYNC] & ~h[SYNC+1];
        acc    = m_valid && s_rdy;
        acc_ch = acc ? m_id : -1;
        for (int i = 0; i < N; i++) begin
            kept  = m_pend[i] && (i != acc_ch);
            np[i] = rise[i] || kept;
            if (rise[i] && kept) m_ovf[i] = 1'b1;
            else if (s_clr) m_ovf[i] = 1'b0;
        end
        if (!m_valid) begin
            if (m_pend != 0) begin
                m_valid = 1;
                m_id    = rr_search(m_pend, m_ptr);
            end
        end else if (acc) begin
            m_ptr = (m_id + 1) % N;
            j     = rr_search(np, m_ptr);
            if (j >= 0) m_id = j;
            else m_valid = 0;
        end
        m_pend = np;
        for (int k = 3; k > 0; k--) h[k] = h[k-1];
        h[0] = s_in;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    task automatic exp4(input string tag, input logic v, input int id, input logic [N-1:0] p, input logic [N-1:0] o);
        chk({tag, "_valid"}, int'(evt_valid), int'(v));
        chk({tag, "_id"}, int'(evt_id), id);
        chk({tag, "_pend"}, int'(pend), int'(p));
        chk({tag, "_ovf"}, int'(ovf), int'(o));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge(in_s, rdy, clr);
        #1;
        chk("m_valid", int'(evt_valid), int'(m_valid));
        chk("m_id", int'(evt_id), m_id);
        chk("m_pend", int'(pend), int'(m_pend));
        chk("m_ovf", int'(ovf), int'(m_ovf));
    endtask

    typedef struct {
        logic [N-1:0] in;
        logic         rdy;
        logic         clr;
        logic         v;
        int           id;
        logic [N-1:0] p;
        logic [N-1:0] o;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [N-1:0] i, input logic r, input logic c,
                       input logic v, input int id, input logic [N-1:0] p, input logic [N-1:0] o);
        vec_t e;
        e.in = i; e.rdy = r; e.clr = c; e.v = v; e.id = id; e.p = p; e.o = o;
        tbl.push_back(e);
    endtask

    initial begin
        int grants;
        int n;
        logic [N-1:0] mask;

        rst_n = 1'b0;
        in_s  = '0;
        rdy   = 1'b0;
        clr   = 1'b0;
        model_reset();
        repeat (3) tick();
        exp4("reset", 1'b0, 0, 4'b0000, 4'b0000);
        rst_n = 1'b1;

`ifndef EDGE_SYNC_EN
        // single event on channel 2, held, then accepted
        add(4'b0100, 0, 0, 0, 0, 4'b0000, 4'b0000);
        add(4'b0100, 0, 0, 0, 0, 4'b0100, 4'b0000);
        add(4'b0100, 0, 0, 1, 2, 4'b0100, 4'b0000);
        add(4'b0100, 0, 0, 1, 2, 4'b0100, 4'b0000);
        add(4'b0100, 1, 0, 0, 2, 4'b0000, 4'b0000);
        add(4'b0000, 1, 0, 0, 2, 4'b0000, 4'b0000);
        // channel 3 alone moves ptr back to 0
        add(4'b1000, 1, 0, 0, 2, 4'b0000, 4'b0000);
        add(4'b1000, 1, 0, 0, 2, 4'b1000, 4'b0000);
        add(4'b1000, 1, 0, 1, 3, 4'b1000, 4'b0000);
        add(4'b1000, 1, 0, 0, 3, 4'b0000, 4'b0000);
        add(4'b0000, 1, 0, 0, 3, 4'b0000, 4'b0000);
        // 0,1,3 together from ptr 0
        add(4'b1011, 1, 0, 0, 3, 4'b0000, 4'b0000);
        add(4'b1011, 1, 0, 0, 3, 4'b1011, 4'b0000);
        add(4'b1011, 1, 0, 1, 0, 4'b1011, 4'b0000);
        add(4'b1011, 1, 0, 1, 1, 4'b1010, 4'b0000);
        add(4'b1011, 1, 0, 1, 3, 4'b1000, 4'b0000);
        add(4'b1011, 1, 0, 0, 3, 4'b0000, 4'b0000);
        add(4'b0000, 1, 0, 0, 3, 4'b0000, 4'b0000);
        // channel 1 alone leaves ptr at 2
        add(4'b0010, 1, 0, 0, 3, 4'b0000, 4'b0000);
        add(4'b0010, 1, 0, 0, 3, 4'b0010, 4'b0000);
        add(4'b0010, 1, 0, 1, 1, 4'b0010, 4'b0000);
        add(4'b0010, 1, 0, 0, 1, 4'b0000, 4'b0000);
        add(4'b0000, 1, 0, 0, 1, 4'b0000, 4'b0000);
        // 0,1,3 together from ptr 2
        add(4'b1011, 1, 0, 0, 1, 4'b0000, 4'b0000);
        add(4'b1011, 1, 0, 0, 1, 4'b1011, 4'b0000);
        add(4'b1011, 1, 0, 1, 3, 4'b1011, 4'b0000);
        add(4'b1011, 1, 0, 1, 0, 4'b0011, 4'b0000);
        add(4'b1011, 1, 0, 1, 1, 4'b0010, 4'b0000);
        add(4'b1011, 1, 0, 0, 1, 4'b0000, 4'b0000);

        for (int r = 0; r < tbl.size(); r++) begin
            in_s = tbl[r].in;
            rdy  = tbl[r].rdy;
            clr  = tbl[r].clr;
            tick();
            exp4($sformatf("row%0d", r), tbl[r].v, tbl[r].id, tbl[r].p, tbl[r].o);
        end

        // overflow on channel 1, clear, then clear colliding with a new set
        rdy = 1'b0; in_s = 4'b0000; tick();
        in_s = 4'b0010; tick();
        in_s = 4'b0000; tick();
        exp4("ovf_pend", 1'b0, 1, 4'b0010, 4'b0000);
        in_s = 4'b0010; tick();
        tick();
        exp4("ovf_set", 1'b1, 1, 4'b0010, 4'b0010);
        clr = 1'b1; tick();
        exp4("ovf_clr", 1'b1, 1, 4'b0010, 4'b0000);
        clr = 1'b0; in_s = 4'b0000; tick();
        in_s = 4'b0010; tick();
        clr = 1'b1; tick();
        exp4("ovf_clr_vs_set", 1'b1, 1, 4'b0010, 4'b0010);
        rdy = 1'b1; tick();
        exp4("ovf_accept", 1'b0, 1, 4'b0000, 4'b0000);
        clr = 1'b0; rdy = 1'b0; in_s = 4'b0000; tick();

        // accept of channel 0 coincides with a new rise on channel 0
        in_s = 4'b0001; tick();
        in_s = 4'b0000; tick();
        in_s = 4'b0001; tick();
        exp4("coll_offer", 1'b1, 0, 4'b0001, 4'b0000);
        rdy = 1'b1; in_s = 4'b0000; tick();
        exp4("coll_regrant", 1'b1, 0, 4'b0001, 4'b0000);
        tick();
        exp4("coll_done", 1'b0, 0, 4'b0000, 4'b0000);
        rdy = 1'b0; tick();

        // asynchronous reset while offering id 3 with pend 1010
        in_s = 4'b1000; tick();
        in_s = 4'b1010; tick();
        tick();
        exp4("pre_rst", 1'b1, 3, 4'b1010, 4'b0000);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        exp4("mid_rst", 1'b0, 0, 4'b0000, 4'b0000);
        in_s = 4'b1000;
        repeat (2) tick();
        rst_n = 1'b1;
        rdy   = 1'b1;
        grants = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (evt_valid) begin
                grants++;
                chk("rel_id", int'(evt_id), 3);
            end
        end
        chk("rel_grants", grants, 1);
        rdy = 1'b0; in_s = 4'b0000;
        repeat (3) tick();
`endif

        // rise-to-valid latency
        in_s = 4'b0100;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            n++;
            if (evt_valid) break;
        end
        chk("latency", n, 3 + SYNC);
        rdy = 1'b1; tick();

        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) mask[i] = ($urandom_range(0, 3) == 0);
            in_s = in_s ^ mask;
            rdy  = 1'($urandom_range(0, 1));
            clr  = ($urandom_range(0, 15) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/edge_event_arbiter.md
Name: edge_event_arbiter

Overview:
- Multi-channel rising-edge event scheduler.
- Per channel: a Moore-style rising-edge detector plus one pending flag.
- Pending events share a single downstream consumer through a round-robin arbiter with a valid/ready handshake.
- Sits between raw level inputs (buttons, status lines) and a single event-processing FSM.

Parameters:
- N, 4: number of input channels; legal range 2..16.
- IDW, $clog2(N): derived width of evt_id; not overridden.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  reset; asynchronous assert, active-low.
- in  input  N  level inputs, one per channel; assumed synchronous to clk unless EDGE_SYNC_EN is defined.
- evt_ready  input  1  consumer accepts the offered event.
- ovf_clr  input  1  synchronous clear of all ovf bits.
- evt_valid  output  1  an event is offered.
- evt_id  output  IDW  channel index of the offered event.
- pend  output  N  pending-event flags.
- ovf  output  N  sticky per-channel overflow flags.

Behaviour:
- Reset (rst_n=0, asynchronous): in_q, in_qq, pend, ovf and ptr are 0; state is IDLE; evt_valid=0; evt_id=0.
- A level already high at reset release yields exactly one event.
- Edge detect, per channel:
  - in_q <= in; in_qq <= in_q.
  - rise[i] = in_q[i] & ~in_qq[i].
  - Purely registered; no combinational path from in.
- Latency, with E0 = first edge sampling in[i]=1:
  - rise[i] is high between E0 and E1.
  - pend[i] sets at E1.
  - evt_valid rises at E2 if the arbiter is idle.
- Accept: acc = evt_valid & evt_ready at a clock edge.
- Pending update at each edge:
  - pend[i] <= rise[i] | (pend[i] & ~(acc & evt_id==i)).
  - Rise on the channel being accepted in the same edge: pend stays 1 (new event); no overflow.
- Overflow at each edge:
  - ovf[i] is set when rise[i] & pend[i] & ~(acc & evt_id==i). The events merge and pend stays 1.
  - ovf_clr clears all ovf bits. If ovf_clr and a set hit the same bit in the same edge, the set wins.
- Round-robin pick:
  - Search from index ptr upward, wrapping modulo N.
  - Candidate vector cand = pend with the accepted bit cleared, OR rise.
  - ptr resets to 0. On each acc, ptr <= (evt_id+1) mod N, with wrap from N-1 to 0.
- FSM states: IDLE, OFFER.
  - IDLE: evt_valid=0. If pend != 0, go to OFFER and register evt_id = pick(pend) at that edge.
  - OFFER: evt_valid=1. evt_id is held stable while evt_ready=0.
  - OFFER with acc and cand != 0: stay in OFFER, evt_id <= pick(cand). This gives back-to-back grants, one per cycle.
  - OFFER with acc and cand == 0: go to IDLE. evt_id holds its last value.
- evt_valid never drops without acc, except on reset.
- Reset mid-offer: evt_valid drops immediately (asynchronously) and all pending events are discarded.
- Widths:
  - ptr and evt_id are IDW bits.
  - For non-power-of-2 N, indices >= N are never produced.

Optional Feature:
- Macro: EDGE_SYNC_EN.
- Defined: a 2-flop synchronizer (reset to 0) is inserted per channel ahead of in_q. It adds 2 cycles of latency, so evt_valid rises 4 edges after the first edge sampling in=1 at the synchronizer input.
- Undefined: in feeds in_q directly; latency as stated in Behaviour.
- All other behaviour is identical in both cases.

Test Plan:
- Reset and single event: N=4, rst_n released with in=0. Raise in[2] before edge E0, evt_ready=0 → pend=4'b0100 after E1; evt_valid=1 and evt_id=2 after E2, held while evt_ready=0. Set evt_ready=1 → pend=0, evt_valid=0 next cycle, ptr=3.
- Round-robin fairness: in rises on channels 0, 1 and 3 in the same cycle, evt_ready=1 constant → grants 0, 1, 3 on consecutive cycles with no bubble. Repeat with ptr=2 → grants 3, 0, 1.
- Overflow: pulse in[1] twice (0→1→0→1) while evt_ready=0 → pend[1]=1, ovf[1]=1. Pulse ovf_clr → ovf=0. ovf_clr in the same edge as a new overflow → ovf[1] stays 1.
- Accept/rise collision: channel 0 is being accepted in the same edge that rise[0]=1 → pend[0] stays 1, ovf[0]=0, and a second grant of id 0 follows.
- Reset mid-offer: evt_valid=1, evt_id=3, pend=4'b1010, assert rst_n=0 asynchronously between edges → evt_valid, pend and ovf are 0 immediately. A held-high input after release produces exactly one event.
- EDGE_SYNC_EN build: repeat the single-event scenario → evt_valid asserts 2 cycles later than in the default build; all else matches.
